// File: rtl/dircc_gals_receive_dispatch.sv
// Receive-side dispatcher: accepts one packet, fetches its device state, hands both
// to the handler, waits (bounded) for the reply, and writes the updated state back.
module dircc_gals_receive_dispatch #(
  parameter int PACKET_WIDTH    = 128,
  parameter int STATE_WIDTH     = 128,
  parameter int DEV_ADDR_W      = 4,
  parameter int NUM_DEVICES     = 16,
  parameter int TIMEOUT         = 255,
  parameter int DONE_BIT        = 0,
  // dircc_state sits above the 32-bit dircc_state_extra field in device_state_t
  parameter int DIRCC_STATE_LSB = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PACKET_WIDTH-1:0] in_packet,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    state_rd_en,
  output logic [DEV_ADDR_W-1:0]   state_addr,
  input  logic [STATE_WIDTH-1:0]  state_rd_data,
  output logic                    state_wr_en,
  output logic [STATE_WIDTH-1:0]  state_wr_data,
  output logic [PACKET_WIDTH-1:0] packet_in,
  output logic                    packet_in_valid,
  output logic                    receive_done,
  output logic [7:0]              edge_id,
  output logic [7:0]              port_id,
  output logic [STATE_WIDTH-1:0]  read_state,
  input  logic [STATE_WIDTH-1:0]  write_state,
  input  logic                    write_state_valid,
  input  logic                    packet_handled,
  output logic                    device_done,
  output logic [15:0]             drop_count,
  output logic                    timeout_err
);

  localparam int DONE_POS = DIRCC_STATE_LSB + DONE_BIT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT_RD,
    S_DISPATCH,
    S_WAIT_H,
    S_WRITEBACK
  } state_e;

  state_e                  state_q;
  logic [PACKET_WIDTH-1:0] pkt_q;
  logic [7:0]              edge_q;
  logic [7:0]              port_q;
  logic [DEV_ADDR_W-1:0]   addr_q;
  logic [STATE_WIDTH-1:0]  rd_state_q;
  logic [STATE_WIDTH-1:0]  wr_data_q;
  logic                    rd_en_q;
  logic                    wr_en_q;
  logic                    rcv_done_q;
  logic                    pkt_valid_q;
  logic                    done_q;
  logic                    timeout_q;
  logic [15:0]             drop_q;
  logic [7:0]              cnt_q;

  logic [7:0] dev_idx;
  logic       dev_ok;
  logic [8:0] cnt_inc;

  assign dev_idx = in_packet[7:0];
  assign dev_ok  = (32'(dev_idx) < NUM_DEVICES);
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  // Strobes are set one edge early so each is high exactly while its state is current.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pkt_q       <= '0;
      edge_q      <= '0;
      port_q      <= '0;
      addr_q      <= '0;
      rd_state_q  <= '0;
      wr_data_q   <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      rcv_done_q  <= 1'b0;
      pkt_valid_q <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      drop_q      <= '0;
      cnt_q       <= '0;
    end else begin
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      rcv_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            pkt_q  <= in_packet;
            edge_q <= in_packet[23:16];
            port_q <= in_packet[15:8];
            if (dev_ok) begin
              addr_q  <= dev_idx[DEV_ADDR_W-1:0];
              rd_en_q <= 1'b1;
              state_q <= S_READ;
            end else if (drop_q != 16'hFFFF) begin
              drop_q <= drop_q + 16'd1;
            end
          end
        end
        S_READ: begin
          state_q <= S_WAIT_RD;
        end
        S_WAIT_RD: begin
          rd_state_q  <= state_rd_data;
          rcv_done_q  <= 1'b1;
          pkt_valid_q <= 1'b1;
          state_q     <= S_DISPATCH;
        end
        S_DISPATCH: begin
          cnt_q   <= '0;
          state_q <= S_WAIT_H;
        end
        S_WAIT_H: begin
          cnt_q <= cnt_inc[7:0];
          // A reply on the final permitted cycle still wins over the timeout.
          if (packet_handled) begin
            pkt_valid_q <= 1'b0;
            if (write_state_valid) begin
              wr_data_q <= write_state;
              wr_en_q   <= 1'b1;
              state_q   <= S_WRITEBACK;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (cnt_inc == 9'(TIMEOUT)) begin
            pkt_valid_q <= 1'b0;
            timeout_q   <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_WRITEBACK: begin
          if (wr_data_q[DONE_POS]) begin
            done_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready        = (state_q == S_IDLE);
  assign state_rd_en     = rd_en_q;
  assign state_wr_en     = wr_en_q;
  assign state_addr      = addr_q;
  assign state_wr_data   = wr_data_q;
  assign packet_in       = pkt_q;
  assign packet_in_valid = pkt_valid_q;
  assign receive_done    = rcv_done_q;
  assign edge_id         = edge_q;
  assign port_id         = port_q;
  assign read_state      = rd_state_q;
  assign device_done     = done_q;
  assign drop_count      = drop_q;
  assign timeout_err     = timeout_q;

endmodule

// File: tb/tb_dircc_gals_receive_dispatch.sv
// Bench for the receive dispatcher: transaction-level reference (expected cycle offsets,
// reference state RAM, status flags) driven by directed and $urandom stimulus.
module tb_dircc_gals_receive_dispatch;
  localparam int PW = 128;
  localparam int SW = 128;
  localparam int AW = 4;
  localparam int ND = 16;
  localparam int TO = 255;
  localparam int DB = 0;
  localparam int DL = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [PW-1:0] in_packet = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          state_rd_en;
  logic [AW-1:0] state_addr;
  logic [SW-1:0] state_rd_data;
  logic          state_wr_en;
  logic [SW-1:0] state_wr_data;
  logic [PW-1:0] packet_in;
  logic          packet_in_valid;
  logic          receive_done;
  logic [7:0]    edge_id;
  logic [7:0]    port_id;
  logic [SW-1:0] read_state;
  logic [SW-1:0] write_state = '0;
  logic          write_state_valid = 1'b0;
  logic          packet_handled = 1'b0;
  logic          device_done;
  logic [15:0]   drop_count;
  logic          timeout_err;

  dircc_gals_receive_dispatch #(
    .PACKET_WIDTH(PW), .STATE_WIDTH(SW), .DEV_ADDR_W(AW), .NUM_DEVICES(ND),
    .TIMEOUT(TO), .DONE_BIT(DB), .DIRCC_STATE_LSB(DL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_packet(in_packet), .in_valid(in_valid),
    .in_ready(in_ready), .state_rd_en(state_rd_en), .state_addr(state_addr),
    .state_rd_data(state_rd_data), .state_wr_en(state_wr_en), .state_wr_data(state_wr_data),
    .packet_in(packet_in), .packet_in_valid(packet_in_valid), .receive_done(receive_done),
    .edge_id(edge_id), .port_id(port_id), .read_state(read_state),
    .write_state(write_state), .write_state_valid(write_state_valid),
    .packet_handled(packet_handled), .device_done(device_done),
    .drop_count(drop_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // State RAM: 1-cycle read latency; bench preload port used only during reset.
  logic [SW-1:0] ram [ND];
  logic          tb_wr = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [SW-1:0] tb_data = '0;
  always @(posedge clk) begin
    if (state_rd_en) state_rd_data <= ram[state_addr];
    if (state_wr_en) ram[state_addr] <= state_wr_data;
    else if (tb_wr) ram[tb_addr] <= tb_data;
  end

  logic [SW-1:0] ref_ram [ND];
  int  drop_ref = 0;
  bit  done_ref = 1'b0;
  bit  tout_ref = 1'b0;
  int  n_chk = 0;
  int  n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // mode: 0 reply with state, 1 reply without state, 2 handler silent
  // dn: 0 done bit clear, 1 set, 2 random
  task automatic run_txn(input logic [7:0] dev, input logic [7:0] prt, input logic [7:0] ed,
                         input int mode, input int d, input bit hold, input int dn);
    logic [PW-1:0] pkt;
    logic [SW-1:0] y;
    logic [SW-1:0] rs;
    logic [SW-1:0] wr_dat;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic [7:0]    e_seen;
    logic [7:0]    p_seen;
    logic [PW-1:0] pk_seen;
    int rd_cyc, rc_cyc, wr_cyc, wr_n, pv_cnt, end_cyc, exp_end;
    bit good;
    pkt = rnd128();
    pkt[7:0] = dev;
    pkt[15:8] = prt;
    pkt[23:16] = ed;
    y = rnd128();
    y[DL+DB] = (dn == 2) ? ($urandom_range(0, 3) == 0) : (dn == 1);
    good = (int'(dev) < ND);
    rd_cyc = -1; rc_cyc = -1; wr_cyc = -1; wr_n = 0; pv_cnt = 0; end_cyc = -1;
    rs = '0; wr_dat = '0; rd_addr = '0; wr_addr = '0; e_seen = '0; p_seen = '0; pk_seen = '0;
    check_eq("ready_before_accept", in_ready, 1'b1);
    in_packet = pkt;
    in_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      if (state_rd_en && rd_cyc < 0) begin rd_cyc = n; rd_addr = state_addr; end
      if (receive_done && rc_cyc < 0) begin
        rc_cyc = n; e_seen = edge_id; p_seen = port_id; pk_seen = packet_in; rs = read_state;
      end
      if (packet_in_valid) pv_cnt++;
      if (state_wr_en) begin wr_n++; wr_cyc = n; wr_addr = state_addr; wr_dat = state_wr_data; end
      if (in_ready) begin end_cyc = n; break; end
      packet_handled    = (mode != 2) && (n == 3 + d);
      write_state_valid = (mode == 0) && (n == 3 + d);
      write_state       = y;
      @(posedge clk); #1;
    end
    packet_handled = 1'b0;
    write_state_valid = 1'b0;
    if (end_cyc < 0) check_eq("txn_cycle_bound", 1'b0, 1'b1);
    if (!good) begin
      drop_ref = (drop_ref == 16'hFFFF) ? drop_ref : drop_ref + 1;
      exp_end = 1;
      check_eq("drop_no_read", rd_cyc, -1);
    end else begin
      check_eq("rd_cycle", rd_cyc, 1);
      check_eq("rd_addr", rd_addr, dev[AW-1:0]);
      check_eq("recv_done_cycle", rc_cyc, 3);
      check_eq("edge_id", e_seen, ed);
      check_eq("port_id", p_seen, prt);
      check_eq("packet_in", pk_seen, pkt);
      check_eq("read_state", rs, ref_ram[dev[AW-1:0]]);
      if (mode == 2) begin
        exp_end = 4 + TO;
        tout_ref = 1'b1;
        check_eq("pv_cycles", pv_cnt, TO + 1);
      end else begin
        exp_end = (mode == 0) ? 5 + d : 4 + d;
        check_eq("pv_cycles", pv_cnt, d + 1);
      end
      if (mode == 0) begin
        check_eq("wr_cycle", wr_cyc, 4 + d);
        check_eq("wr_addr", wr_addr, dev[AW-1:0]);
        check_eq("wr_data", wr_dat, y);
        ref_ram[dev[AW-1:0]] = y;
        done_ref = done_ref | y[DL+DB];
      end
      check_eq("ram_content", ram[dev[AW-1:0]], ref_ram[dev[AW-1:0]]);
    end
    check_eq("wr_count", wr_n, (good && mode == 0) ? 1 : 0);
    check_eq("end_cycle", end_cyc, exp_end);
    check_eq("drop_count", drop_count, drop_ref[15:0]);
    check_eq("device_done", device_done, done_ref);
    check_eq("timeout_err", timeout_err, tout_ref);
  endtask

  initial begin
    int silent_left;
    int r, md;
    int wr_seen;
    for (int i = 0; i < ND; i++) begin
      ref_ram[i] = rnd128();
      ref_ram[i][DL+DB] = 1'b0;
      @(posedge clk); #1;
      tb_wr = 1'b1; tb_addr = AW'(i); tb_data = ref_ram[i];
    end
    @(posedge clk); #1;
    tb_wr = 1'b0;
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_rd_en", state_rd_en, 1'b0);
    check_eq("rst_wr_en", state_wr_en, 1'b0);
    check_eq("rst_recv_done", receive_done, 1'b0);
    check_eq("rst_pv", packet_in_valid, 1'b0);
    check_eq("rst_read_state", read_state, '0);
    check_eq("rst_packet_in", packet_in, '0);
    check_eq("rst_ids", {edge_id, port_id, 4'(state_addr)}, '0);
    check_eq("rst_status", {device_done, timeout_err, drop_count}, '0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_txn(8'd3, 8'd1, 8'd2, 0, 1, 1'b0, 0);        // normal, 1-cycle handler
    run_txn(8'd20, 8'd4, 8'd5, 0, 1, 1'b0, 0);       // bad device index
    check_eq("drop_ready_stays", in_ready, 1'b1);
    run_txn(8'd16, 8'd0, 8'd0, 0, 1, 1'b0, 0);       // first out-of-range index
    run_txn(8'd15, 8'd9, 8'd8, 0, 2, 1'b0, 0);       // last valid index
    run_txn(8'd6, 8'd2, 8'd3, 2, 1, 1'b0, 0);        // handler silent -> timeout
    run_txn(8'd7, 8'd3, 8'd1, 0, TO, 1'b0, 0);       // reply on last permitted cycle
    run_txn(8'd8, 8'd1, 8'd1, 1, 2, 1'b0, 0);        // reply without state
    run_txn(8'd9, 8'd5, 8'd6, 0, 1, 1'b0, 1);        // done bit set
    run_txn(8'd10, 8'd5, 8'd6, 0, 3, 1'b0, 0);       // done stays sticky
    run_txn(8'd1, 8'd1, 8'd1, 0, 1, 1'b1, 2);        // back-to-back, in_valid held
    run_txn(8'd2, 8'd2, 8'd2, 0, 1, 1'b1, 2);
    run_txn(8'd4, 8'd3, 8'd3, 0, 1, 1'b1, 2);
    in_valid = 1'b0;

    silent_left = 2;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 19);
      if (r == 0 && silent_left > 0) begin md = 2; silent_left--; end
      else if (r <= 3) md = 1;
      else md = 0;
      run_txn(8'($urandom_range(0, 21)), 8'($urandom), 8'($urandom), md,
              $urandom_range(1, 5), 1'($urandom_range(0, 1)), 2);
    end
    in_valid = 1'b0;

    // Reset in the middle of WAIT_H with a reply pending: no write may follow.
    in_packet = rnd128();
    in_packet[7:0] = 8'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("mid_pv_before_reset", packet_in_valid, 1'b1);
    packet_handled = 1'b1;
    write_state_valid = 1'b1;
    write_state = rnd128();
    reset_n = 1'b0;
    #1;
    drop_ref = 0; done_ref = 1'b0; tout_ref = 1'b0;
    check_eq("mid_rst_in_ready", in_ready, 1'b1);
    check_eq("mid_rst_strobes", {state_rd_en, state_wr_en, receive_done, packet_in_valid}, '0);
    check_eq("mid_rst_status", {device_done, timeout_err, drop_count}, '0);
    @(posedge clk); #1;
    packet_handled = 1'b0;
    write_state_valid = 1'b0;
    reset_n = 1'b1;
    wr_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (state_wr_en) wr_seen++;
    end
    check_eq("mid_rst_no_write", wr_seen, 0);
    check_eq("mid_rst_ram", ram[5], ref_ram[5]);
    check_eq("mid_rst_idle", in_ready, 1'b1);
    run_txn(8'd5, 8'd1, 8'd1, 0, 1, 1'b0, 0);        // clean transaction after reset

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
